mdu_iter: RTL and testbench

- Multi-cycle multiply/divide unit with architectural HI/LO registers; the sequential successor to the single-cycle combinational mult/div ALU.
- Width is parametrised. Uses an iterative shift-add multiplier and a restoring divider, one bit per cycle.
- Start/busy/done handshake toward the pipeline control. A kill input lets the pipeline abort an op on an exception.
- Sits beside the main ALU in EX; the pipeline stalls on MFHI/MFLO while busy=1.

---
 rtl/mdu_iter.sv | 189 ++++++++++++++++++
 tb/tb_mdu_iter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit with architectural HI/LO registers.
//
// Multiplies with a one-bit-per-cycle shift-add datapath and divides with a
// one-bit-per-cycle restoring divider; both share one 2*WIDTH work register.
// An accepted op takes WIDTH+2 cycles (PREP, WIDTH x CALC, FIX) and commits
// HI/LO together with a one-cycle done pulse.
//
// Optional build macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (ops 4-7)
// and the accumulator snapshot register. Without it, ops 4-7 are refused.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start, op       op request (0 MULT,1 MULTU,2 DIV,3 DIVU,4-7 MADD/MADDU/MSUB/MSUBU)
//   rs1, rs2        multiplicand/dividend, multiplier/divisor
//   kill            abort the in-flight op (no commit, no done)
//   hi_we, lo_we    MTHI/MTLO strobes, honoured only while idle and not starting
//   wdata           MTHI/MTLO data
//   busy, done      op in flight; one-cycle commit pulse
//   hi_o, lo_o      HI and LO registers
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic             kill,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   rs1_q, rs2_q, opnd_q, hi_q, lo_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [CW-1:0]      cnt_q;
  logic               sign_res_q, sign_rem_q, done_q;

  logic               op_legal, accept, op_signed, op_div;
  logic [WIDTH-1:0]   abs1, abs2;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_signed, result;

`ifdef MDU_MADD_EN
  logic [2*WIDTH-1:0] acc_q;
  assign op_legal = 1'b1;
`else
  assign op_legal = ~op[2];
`endif

  assign accept    = (state_q == IDLE) && start && op_legal;
  // Even op codes are the signed flavours; ops 2 and 3 are the divides.
  assign op_signed = ~op_q[0];
  assign op_div    = (op_q[2:1] == 2'b01);
  assign abs1      = (op_signed && rs1_q[WIDTH-1]) ? -rs1_q : rs1_q;
  assign abs2      = (op_signed && rs2_q[WIDTH-1]) ? -rs2_q : rs2_q;

  // Multiply step: prod_q holds {partial sum, remaining multiplier bits};
  // add the multiplicand into the top half when the multiplier LSB is set,
  // then shift the whole register right by one.
  assign mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
  // Divide step: prod_q holds {partial remainder, dividend/quotient bits};
  // shift the next dividend bit into the remainder and trial-subtract.
  assign div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; kill overrides every non-idle transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = PREP;
      PREP: state_d = CALC;
      CALC: if (cnt_q == '0) state_d = FIX;
      FIX:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill && state_q != IDLE) state_d = IDLE;
  end

  // Commit value. DIV of MIN by -1 needs no special case: |MIN| / 1 is the
  // unsigned value 2^(WIDTH-1), both signs are negative so no negation is
  // applied, and the remainder is zero.
  assign prod_signed = sign_res_q ? -prod_q : prod_q;

  always_comb begin
    result = prod_signed;
    if (op_div) begin
      if (rs2_q == '0)
        result = {rs1_q, (op_signed && rs1_q[WIDTH-1]) ? WIDTH'(1) : {WIDTH{1'b1}}};
      else
        result = {sign_rem_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH],
                  sign_res_q ? -prod_q[WIDTH-1:0]       : prod_q[WIDTH-1:0]};
    end
`ifdef MDU_MADD_EN
    if (!op_div && op_q[2])
      result = op_q[1] ? acc_q - prod_signed : acc_q + prod_signed;
`endif
  end

  // Datapath: latch operands on accept, normalise signs in PREP, then run
  // one multiply or divide step per CALC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      opnd_q     <= '0;
      prod_q     <= '0;
      cnt_q      <= '0;
      sign_res_q <= 1'b0;
      sign_rem_q <= 1'b0;
`ifdef MDU_MADD_EN
      acc_q      <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          op_q  <= op;
          rs1_q <= rs1;
          rs2_q <= rs2;
        end
        PREP: begin
          opnd_q     <= op_div ? abs2 : abs1;
          prod_q     <= {{WIDTH{1'b0}}, op_div ? abs1 : abs2};
          cnt_q      <= CW'(WIDTH - 1);
          sign_res_q <= op_signed & (rs1_q[WIDTH-1] ^ rs2_q[WIDTH-1]);
          sign_rem_q <= op_signed & rs1_q[WIDTH-1];
`ifdef MDU_MADD_EN
          acc_q      <= {hi_q, lo_q};
`endif
        end
        CALC: begin
          cnt_q <= cnt_q - 1'b1;
          if (op_div) begin
            if (!div_diff[WIDTH])
              prod_q <= {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
            else
              prod_q <= {div_shift[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
          end else begin
            prod_q <= {mul_sum, prod_q[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  // HI/LO: committed by an unkilled FIX, otherwise written by MTHI/MTLO only
  // when idle and no start is being accepted on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == FIX) && !kill;
      if (state_q == FIX && !kill) begin
        hi_q <= result[2*WIDTH-1:WIDTH];
        lo_q <= result[WIDTH-1:0];
      end else if (state_q == IDLE && !accept) begin
        if (hi_we) hi_q <= wdata;
        if (lo_we) lo_q <= wdata;
      end
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: self-checking bench for mdu_iter (WIDTH=32).
// Expected HI/LO come from a plain-arithmetic reference of each op; the
// bench also checks latency, busy width, done pulse, kill and reset behaviour.
module tb_mdu_iter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, kill, hi_we, lo_we;
  logic [2:0]   op;
  logic [W-1:0] rs1, rs2, wdata;
  logic         busy, done;
  logic [W-1:0] hi_o, lo_o;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] m_hi, m_lo;

  mdu_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .kill(kill), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  // Reference: returns {HI, LO} for an op given the current {HI, LO}.
  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] acc);
    logic [63:0] sp, up;
    int sa, sb;
    sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    up = {32'b0, a} * {32'b0, b};
    sa = a;
    sb = b;
    case (o)
      3'd0: return sp;
      3'd1: return up;
      3'd2: begin
        if (b == 0) return {a, a[31] ? 32'd1 : 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        else return {32'(sa % sb), 32'(sa / sb)};
      end
      3'd3: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        else return {a % b, a / b};
      end
      3'd4: return acc + sp;
      3'd5: return acc + up;
      3'd6: return acc - sp;
      default: return acc - up;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  // Call at a negedge; raises start for one edge and returns at the negedge
  // after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges until done is seen (bounded) and samples of busy high.
  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (busy === 1'b1) bcnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; kill = 0; hi_we = 0; lo_we = 0; op = 0; rs1 = 0; rs2 = 0; wdata = 0;
    repeat (2) @(negedge clk);
    checks++; if (hi_o !== 32'd0) begin errors++; $display("[TB] FAIL reset_hi got %h exp 0", hi_o); end
    checks++; if (lo_o !== 32'd0) begin errors++; $display("[TB] FAIL reset_lo got %h exp 0", lo_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b exp 0", done); end
    rst = 1'b0;
    m_hi = 0; m_lo = 0;
    @(negedge clk);
  endtask

  task automatic test_multu_latency();
    int cyc, bcnt;
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(cyc, bcnt);
    checks++; if (cyc !== 34) begin errors++; $display("[TB] FAIL multu_latency got %0d exp 34", cyc); end
    checks++; if (bcnt !== 34) begin errors++; $display("[TB] FAIL multu_busy_cycles got %0d exp 34", bcnt); end
    checks++; if (hi_o !== 32'hFFFFFFFE) begin errors++; $display("[TB] FAIL multu_hi got %h exp fffffffe", hi_o); end
    checks++; if (lo_o !== 32'h00000001) begin errors++; $display("[TB] FAIL multu_lo got %h exp 00000001", lo_o); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL done_pulse_width got %b exp 0", done); end
    m_hi = 32'hFFFFFFFE; m_lo = 32'h1;
  endtask

  task automatic test_directed();
    logic [2:0]  ops [4] = '{3'd0, 3'd2, 3'd3, 3'd2};
    logic [31:0] as  [4] = '{32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100, 32'h80000000};
    logic [31:0] bs  [4] = '{32'd7, 32'd2, 32'd0, 32'hFFFFFFFF};
    logic [31:0] ehi [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100, 32'd0};
    logic [31:0] elo [4] = '{32'hFFFFFFEB, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000};
    int cyc, bcnt;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_done(cyc, bcnt);
      checks++; if (cyc !== 34) begin errors++; $display("[TB] FAIL directed%0d_latency got %0d exp 34", i, cyc); end
      checks++; if (hi_o !== ehi[i]) begin errors++; $display("[TB] FAIL directed%0d_hi got %h exp %h", i, hi_o, ehi[i]); end
      checks++; if (lo_o !== elo[i]) begin errors++; $display("[TB] FAIL directed%0d_lo got %h exp %h", i, lo_o, elo[i]); end
      m_hi = ehi[i]; m_lo = elo[i];
      @(negedge clk);
    end
  endtask

  task automatic test_mthi_busy();
    int cyc, bcnt;
    hi_we = 1; wdata = 32'h1;
    @(negedge clk);
    hi_we = 0; lo_we = 1; wdata = 32'h2;
    @(negedge clk);
    lo_we = 0;
    checks++; if (hi_o !== 32'h1) begin errors++; $display("[TB] FAIL mthi got %h exp 1", hi_o); end
    checks++; if (lo_o !== 32'h2) begin errors++; $display("[TB] FAIL mtlo got %h exp 2", lo_o); end
    issue(3'd1, 32'd3, 32'd5);
    repeat (4) @(negedge clk);
    start = 1; op = 3'd3; rs1 = 32'd9; rs2 = 32'd0; hi_we = 1; lo_we = 1; wdata = 32'hDEAD;
    @(negedge clk);
    start = 0; hi_we = 0; lo_we = 0;
    wait_done(cyc, bcnt);
    checks++; if (cyc + 5 !== 34) begin errors++; $display("[TB] FAIL busy_op_latency got %0d exp 34", cyc + 5); end
    checks++; if (hi_o !== 32'd0) begin errors++; $display("[TB] FAIL busy_write_hi got %h exp 0", hi_o); end
    checks++; if (lo_o !== 32'd15) begin errors++; $display("[TB] FAIL busy_write_lo got %h exp f", lo_o); end
    m_hi = 0; m_lo = 15;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ignored_start_busy got %b exp 0", busy); end
  endtask

  task automatic test_back_to_back();
    int cyc, bcnt;
    issue(3'd3, 32'd1000, 32'd7);
    wait_done(cyc, bcnt);
    issue(3'd0, 32'hFFFFFFFF, 32'h00000010);
    wait_done(cyc, bcnt);
    checks++; if (cyc !== 34) begin errors++; $display("[TB] FAIL b2b_latency got %0d exp 34", cyc); end
    checks++; if (hi_o !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL b2b_hi got %h exp ffffffff", hi_o); end
    checks++; if (lo_o !== 32'hFFFFFFF0) begin errors++; $display("[TB] FAIL b2b_lo got %h exp fffffff0", lo_o); end
    m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFF0;
    @(negedge clk);
  endtask

  task automatic test_kill();
    int seen;
    hi_we = 1; wdata = 32'h55;
    issue(3'd3, 32'd1000, 32'd7);
    hi_we = 0;
    repeat (9) @(negedge clk);
    kill = 1;
    @(negedge clk);
    kill = 0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL kill_busy got %b exp 0", busy); end
    checks++; if (hi_o !== m_hi) begin errors++; $display("[TB] FAIL kill_hi got %h exp %h", hi_o, m_hi); end
    checks++; if (lo_o !== m_lo) begin errors++; $display("[TB] FAIL kill_lo got %h exp %h", lo_o, m_lo); end
    seen = 0;
    repeat (40) begin
      if (done === 1'b1) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL kill_no_done got %0d exp 0", seen); end
  endtask

  task automatic test_kill_fix();
    issue(3'd1, 32'd5, 32'd6);
    repeat (33) @(negedge clk);
    kill = 1;
    @(negedge clk);
    kill = 0;
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL kill_fix_done got %b exp 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL kill_fix_busy got %b exp 0", busy); end
    checks++; if (lo_o !== m_lo) begin errors++; $display("[TB] FAIL kill_fix_lo got %h exp %h", lo_o, m_lo); end
    checks++; if (hi_o !== m_hi) begin errors++; $display("[TB] FAIL kill_fix_hi got %h exp %h", hi_o, m_hi); end
  endtask

  task automatic test_kill_idle();
    int cyc, bcnt;
    kill = 1;
    issue(3'd1, 32'd5, 32'd6);
    kill = 0;
    wait_done(cyc, bcnt);
    checks++; if (cyc !== 34) begin errors++; $display("[TB] FAIL kill_idle_latency got %0d exp 34", cyc); end
    checks++; if (lo_o !== 32'd30) begin errors++; $display("[TB] FAIL kill_idle_lo got %h exp 1e", lo_o); end
    m_hi = 0; m_lo = 30;
    @(negedge clk);
  endtask

`ifdef MDU_MADD_EN
  task automatic test_madd();
    int cyc, bcnt;
    hi_we = 1; wdata = 32'd0;
    @(negedge clk);
    hi_we = 0; lo_we = 1; wdata = 32'd5;
    @(negedge clk);
    lo_we = 0;
    issue(3'd4, 32'd2, 32'd3);
    wait_done(cyc, bcnt);
    checks++; if (cyc !== 34) begin errors++; $display("[TB] FAIL madd_latency got %0d exp 34", cyc); end
    checks++; if (hi_o !== 32'd0) begin errors++; $display("[TB] FAIL madd_hi got %h exp 0", hi_o); end
    checks++; if (lo_o !== 32'd11) begin errors++; $display("[TB] FAIL madd_lo got %h exp b", lo_o); end
    issue(3'd7, 32'd4, 32'd4);
    wait_done(cyc, bcnt);
    checks++; if (hi_o !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL msubu_hi got %h exp ffffffff", hi_o); end
    checks++; if (lo_o !== 32'hFFFFFFFB) begin errors++; $display("[TB] FAIL msubu_lo got %h exp fffffffb", lo_o); end
    m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFFB;
    @(negedge clk);
  endtask
`else
  task automatic test_illegal();
    int seen;
    for (int o = 4; o < 8; o++) begin
      issue(3'(o), 32'd2, 32'd3);
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL illegal_op%0d_busy got %b exp 0", o, busy); end
    end
    seen = 0;
    repeat (40) begin
      if (done === 1'b1) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL illegal_no_done got %0d exp 0", seen); end
    checks++; if (lo_o !== m_lo) begin errors++; $display("[TB] FAIL illegal_lo got %h exp %h", lo_o, m_lo); end
  endtask
`endif

  task automatic test_random();
    int cyc, bcnt;
    logic [2:0]  o;
    logic [31:0] a, b;
    logic [63:0] e;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        hi_we = 1; wdata = $urandom();
        m_hi = wdata;
        @(negedge clk);
        hi_we = 0; lo_we = 1; wdata = $urandom();
        m_lo = wdata;
        @(negedge clk);
        lo_we = 0;
      end
`ifdef MDU_MADD_EN
      o = 3'($urandom_range(0, 7));
`else
      o = 3'($urandom_range(0, 3));
`endif
      a = pick();
      b = pick();
      e = ref_op(o, a, b, {m_hi, m_lo});
      issue(o, a, b);
      wait_done(cyc, bcnt);
      checks++; if (cyc !== 34) begin errors++; $display("[TB] FAIL rand%0d_latency op %0d got %0d exp 34", i, o, cyc); end
      checks++; if (hi_o !== e[63:32]) begin errors++; $display("[TB] FAIL rand%0d_hi op %0d a %h b %h got %h exp %h", i, o, a, b, hi_o, e[63:32]); end
      checks++; if (lo_o !== e[31:0]) begin errors++; $display("[TB] FAIL rand%0d_lo op %0d a %h b %h got %h exp %h", i, o, a, b, lo_o, e[31:0]); end
      m_hi = e[63:32]; m_lo = e[31:0];
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    issue(3'd0, 32'd123, 32'd456);
    repeat (5) @(negedge clk);
    rst = 1;
    #1;
    checks++; if (hi_o !== 32'd0) begin errors++; $display("[TB] FAIL rst_mid_hi got %h exp 0", hi_o); end
    checks++; if (lo_o !== 32'd0) begin errors++; $display("[TB] FAIL rst_mid_lo got %h exp 0", lo_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busy got %b exp 0", busy); end
    @(negedge clk);
    rst = 0;
    m_hi = 0; m_lo = 0;
    seen = 0;
    repeat (40) begin
      if (done === 1'b1) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL rst_mid_no_done got %0d exp 0", seen); end
  endtask

  initial begin
    test_reset();
    test_multu_latency();
    test_directed();
    test_mthi_busy();
    test_back_to_back();
    test_kill();
    test_kill_fix();
    test_kill_idle();
`ifdef MDU_MADD_EN
    test_madd();
`else
    test_illegal();
`endif
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
